// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing stream counter.
// Holds the FSM state enum, default widths and the window-length decoder.
package sc_pkg;

  localparam int SC_LEN_W = 8;
  localparam int SC_RES_W = SC_LEN_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sc_cnt_state_t;

  // A window length of zero stands for the full 2^len_w window.
  function automatic logic [32:0] sc_win_decode(input logic [31:0] win_len, input int len_w);
    logic [32:0] n;
    if (win_len == 32'd0) n = 33'd1 << len_w;
    else n = {1'b0, win_len};
    return n;
  endfunction

endpackage

// File: rtl/sc_window_ctr.sv
// Remaining-bits down-counter for one conversion window.
// Load has priority over enable; last flags the final bit of the window.
module sc_window_ctr
  import sc_pkg::*;
#(
  parameter int LEN_W = SC_LEN_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [LEN_W:0] load_val,
  input  logic           en,
  output logic           last
);

  logic [LEN_W:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load) rem_d = load_val;
    else if (en) rem_d = rem_q - (LEN_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= '0;
    else rem_q <= rem_d;
  end

  assign last = (rem_q == (LEN_W + 1)'(1));

endmodule

// File: rtl/sc_stream_counter.sv
// Converts a stochastic bitstream to binary by counting ones over N valid bits.
// Define SC_BIPOLAR_EN to emit 2*ones - N (bipolar decoding) instead of the raw count.
module sc_stream_counter
  import sc_pkg::*;
#(
  parameter int LEN_W = SC_LEN_W,
  parameter int RES_W = LEN_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] win_len,
  input  logic             sc_bit,
  input  logic             sc_valid,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  sc_cnt_state_t    state_q, state_d;
  logic [LEN_W:0]   ones_q, ones_d, ones_inc, n_load;
  logic [RES_W-1:0] result_q, result_d, result_fin;
  logic             win_load, win_en, win_last;

`ifdef SC_BIPOLAR_EN
  logic [LEN_W:0] n_q;

  function automatic logic [RES_W-1:0] to_result(input logic [LEN_W:0] ones,
                                                 input logic [LEN_W:0] n);
    logic signed [RES_W-1:0] bip;
    bip = $signed(RES_W'({ones, 1'b0})) - $signed(RES_W'(n));
    return bip;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_q <= '0;
    else if (win_load) n_q <= n_load;
  end

  assign result_fin = to_result(ones_inc, n_q);
`else
  function automatic logic [RES_W-1:0] to_result(input logic [LEN_W:0] ones);
    return RES_W'(ones);
  endfunction

  assign result_fin = to_result(ones_inc);
`endif

  assign n_load   = (LEN_W + 1)'(sc_win_decode(32'(win_len), LEN_W));
  assign ones_inc = ones_q + (LEN_W + 1)'(sc_bit);

  sc_window_ctr #(
    .LEN_W(LEN_W)
  ) u_window_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (win_load),
    .load_val(n_load),
    .en      (win_en),
    .last    (win_last)
  );

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    result_d = result_q;
    win_load = 1'b0;
    win_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          win_load = 1'b1;
          ones_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (sc_valid) begin
          win_en = 1'b1;
          ones_d = ones_inc;
          // The final bit is folded into the result on the same edge it is counted.
          if (win_last) begin
            result_d = result_fin;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == HOLD);
  assign result       = result_q;

endmodule

// File: tb/tb_sc_stream_counter.sv
// Self-checking bench for sc_stream_counter: directed and randomized conversions
// checked against a count-the-ones reference model (honours SC_BIPOLAR_EN).
module tb_sc_stream_counter;

  localparam int LEN_W = 8;
  localparam int RES_W = LEN_W + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] win_len;
  logic             sc_bit;
  logic             sc_valid;
  logic             busy;
  logic [RES_W-1:0] result;
  logic             result_valid;
  logic             result_ready;

  int errors = 0;
  int checks = 0;
  int bq[$];
  int vq[$];

  always #5 clk = ~clk;

  sc_stream_counter #(
    .LEN_W(LEN_W),
    .RES_W(RES_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .win_len     (win_len),
    .sc_bit      (sc_bit),
    .sc_valid    (sc_valid),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: unipolar = number of ones; bipolar = 2*ones - N, wrapped to RES_W bits.
  function automatic int expect_result(input int ones, input int n);
    int r;
`ifdef SC_BIPOLAR_EN
    r = 2 * ones - n;
`else
    r = ones;
`endif
    return r & ((1 << RES_W) - 1);
  endfunction

  task automatic conv(input int w, input int hold_n, input bit early_rdy,
                      input int start_run_at, input bit start_in_hold, input bit start_on_acc);
    int n, cnt, ones, exp_r, cyc;
    bit b, v;
    n = (w == 0) ? (1 << LEN_W) : w;
    start = 1'b1;
    win_len = LEN_W'(w);
    sc_bit = 1'b1;
    sc_valid = 1'b1;
    tick();
    start = 1'b0;
    win_len = LEN_W'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    chk("rv_after_start", 32'(result_valid), 0);
    cnt = 0;
    ones = 0;
    cyc = 0;
    while (cnt < n && cyc < 5000) begin
      if (bq.size() > 0) b = bq.pop_front() != 0;
      else b = $urandom_range(0, 1) != 0;
      if (vq.size() > 0) v = vq.pop_front() != 0;
      else v = $urandom_range(0, 3) != 0;
      sc_bit = b;
      sc_valid = v;
      if (cyc == start_run_at) begin
        start = 1'b1;
        win_len = LEN_W'(3);
      end
      result_ready = (v && cnt + 1 == n) ? early_rdy : ($urandom_range(0, 1) != 0);
      tick();
      start = 1'b0;
      if (v) begin
        cnt++;
        ones += int'(b);
      end
      cyc++;
      if (cnt < n) chk("rv_low_in_run", 32'(result_valid), 0);
    end
    chk("window_bits_seen", cnt, n);
    exp_r = expect_result(ones, n);
    chk("rv_rise", 32'(result_valid), 1);
    chk("result", 32'(result), exp_r);
    chk("busy_hold", 32'(busy), 1);
    for (int i = 0; i < hold_n; i++) begin
      result_ready = 1'b0;
      start = start_in_hold && (i == 0);
      sc_bit = $urandom_range(0, 1) != 0;
      sc_valid = $urandom_range(0, 1) != 0;
      tick();
      start = 1'b0;
      chk("rv_held", 32'(result_valid), 1);
      chk("result_held", 32'(result), exp_r);
    end
    result_ready = 1'b1;
    start = start_on_acc;
    win_len = LEN_W'(5);
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk("rv_after_accept", 32'(result_valid), 0);
    chk("busy_after_accept", 32'(busy), 0);
    chk("result_kept", 32'(result), exp_r);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    win_len = '0;
    sc_bit = 1'b0;
    sc_valid = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rv", 32'(result_valid), 0);
    chk("reset_result", 32'(result), 0);
    rst_n = 1'b1;
    tick();

    // Full 256-bit window of ones.
    for (int i = 0; i < 256; i++) begin
      bq.push_back(1);
      vq.push_back(1);
    end
    conv(0, 1, 1'b0, -1, 1'b0, 1'b0);

    // N=16 alternating bits, result held for 5 cycles.
    for (int i = 0; i < 16; i++) begin
      bq.push_back((i % 2 == 0) ? 1 : 0);
      vq.push_back(1);
    end
    conv(16, 5, 1'b0, -1, 1'b0, 1'b0);

    // N=4 with gaps in sc_valid; bits on invalid cycles are ones too.
    bq = '{1, 1, 1, 1, 1, 1, 1};
    vq = '{1, 0, 0, 1, 1, 0, 1};
    conv(4, 0, 1'b0, -1, 1'b0, 1'b0);

    // start during RUN, HOLD and on the accepting edge must all be ignored.
    conv(10, 3, 1'b1, 2, 1'b1, 1'b1);
    tick();
    chk("idle_after_ignored_start", 32'(busy), 0);

    // Asynchronous reset mid-window of N=100.
    start = 1'b1;
    win_len = LEN_W'(100);
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sc_bit = 1'b1;
      sc_valid = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rv", 32'(result_valid), 0);
    chk("abort_result", 32'(result), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_still_idle", 32'(busy), 0);
    bq = '{1, 1, 0};
    vq = '{1, 1, 1};
    conv(3, 0, 1'b0, -1, 1'b0, 1'b0);

    // All zeros over N=8.
    for (int i = 0; i < 8; i++) begin
      bq.push_back(0);
      vq.push_back(1);
    end
    conv(8, 2, 1'b1, -1, 1'b0, 1'b0);

    // Randomized windows, bits, valid gaps and hold lengths.
    for (int k = 0; k < 12; k++) begin
      int w;
      w = (k == 5) ? 0 : $urandom_range(1, 60);
      conv(w, $urandom_range(0, 4), $urandom_range(0, 1) != 0,
           $urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : -1,
           $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      for (int j = 0; j < $urandom_range(0, 2); j++) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_stream_counter.md
Name: sc_stream_counter

Overview:
- Downstream stage of the stochastic-computing core; converts the core's output bitstream (`output_circuit`) back to binary.
- Counts the 1s in `sc_bit` over a programmable window of N valid cycles.
- Presents the count on a valid/ready handshake for the result collector.
- One conversion per `start` pulse; the upstream SNG/LFSR runs freely and qualifies each bit with `sc_valid`.

Parameters:
- LEN_W, 8, log2 of the maximum window length; max window = 2^LEN_W = 256.
- RES_W, LEN_W+2, result width; holds the unipolar count 0..2^LEN_W and the bipolar range −2^LEN_W..+2^LEN_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a conversion; accepted only in IDLE.
- win_len  input  LEN_W  window length N, sampled with an accepted `start`; 0 encodes 2^LEN_W.
- sc_bit  input  1  stochastic bit from the core (`output_circuit`).
- sc_valid  input  1  qualifies `sc_bit`; cycles with `sc_valid`=0 are not counted and do not advance the window.
- busy  output  1  high in RUN and HOLD.
- result  output  RES_W  conversion result; stable while `result_valid`=1.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync deassert at the system level):
  - state=IDLE.
  - `busy`=0, `result_valid`=0, `result`=0.
  - Internal ones-counter and remaining-counter = 0.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - `start`=1 → latch N = (`win_len`==0 ? 2^LEN_W : `win_len`).
  - Clear ones=0, set rem=N, go to RUN; `busy`=1 from the next cycle.
- RUN:
  - Each cycle with `sc_valid`=1: ones += `sc_bit`, rem −= 1.
  - When a valid cycle occurs with rem==1 (the last bit): go to HOLD and register `result` from the final count, including that last bit. `result_valid` rises in the same edge.
  - Latency: `result_valid` asserts 1 cycle after the Nth valid bit is sampled.
  - Cycles with `sc_valid`=0: no change.
- HOLD:
  - `result_valid`=1 and `result` frozen until `result_ready`=1 is sampled.
  - On acceptance: go to IDLE; `result_valid` and `busy` clear on that edge. `result` keeps its last value.
  - `result_ready` high on the same edge `result_valid` rises is not an acceptance; acceptance requires `result_valid`=1 already registered.
- `start` in RUN or HOLD: ignored. No queuing, no restart.
- `start` in the same cycle as HOLD acceptance: ignored; the consumer must re-issue it from IDLE.
- Arithmetic:
  - ones is LEN_W+1 bits and cannot overflow because ones ≤ N ≤ 2^LEN_W.
  - Unipolar result = ones zero-extended to RES_W.
- Reset asserted mid-RUN or mid-HOLD: immediate abort; all state returns to reset values and the partial count is discarded.

Optional Feature:
- Macro: SC_BIPOLAR_EN.
- Defined: `result` = 2·ones − N in two's complement, RES_W bits (bipolar SC decoding). Computed combinationally from the final count and registered into `result` on the HOLD transition; no extra cycle.
- Undefined: unipolar count only; no subtractor is synthesized.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package `sc_pkg`:
  - State enum `sc_cnt_state_t` {IDLE, RUN, HOLD}.
  - Constants SC_LEN_W=8 and SC_RES_W=SC_LEN_W+2.
  - Helper function `sc_win_decode(win_len)` mapping 0→2^LEN_W.
- One natural sub-module, `sc_window_ctr`: the down-counting remaining-counter with load, enable and last-bit flag. The top module holds the FSM, the ones accumulator and the result register.

Test Plan:
- `win_len`=0, `sc_bit`=1 and `sc_valid`=1 constantly → `result_valid` 1 cycle after the 256th bit; result=256 (bipolar build: +256).
- `win_len`=16, alternating `sc_bit` 1/0, `sc_valid`=1 → result=8 (bipolar: 0); `result` held while `result_ready`=0 for 5 cycles, then IDLE 1 cycle after `result_ready`=1.
- `win_len`=4, `sc_bit`=1 with `sc_valid` pattern 1,0,0,1,1,0,1 → result=4; `result_valid` asserts exactly 1 cycle after the 7th cycle; invalid cycles never counted.
- `start` pulsed during RUN and again during HOLD → both ignored; the single conversion completes with its original N.
- `rst_n` asserted for 1 cycle mid-RUN of an N=100 window → `busy`=0, `result_valid`=0 and `result`=0 immediately (asynchronous). A new start with N=3 and bits 1,1,0 then gives result=2 (bipolar: +1).
- `sc_bit`=0 for N=8 → result=0 (bipolar: −8, i.e. 0x3F8 in RES_W=10).
